// File: rtl/sprot_pkg.sv
// Shared definitions for the sprot serial protocol. Used by the receiver,
// the transmitter and the testbench.
package sprot_pkg;

  // Receiver/transmitter frame-walking states.
  typedef enum logic [2:0] {
    IDLE,
    DATA,
    PARITY,
    STOP,
    BREAK
  } sprot_state_e;

  // Line levels that frame a word.
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;
  localparam logic IDLE_LVL  = 1'b1;

  // Cycles per frame: start + data bits + parity + stop.
  function automatic int frame_len(input int data_w);
    return data_w + 3;
  endfunction

  // Even parity bit: XOR of the data bits (callers zero-extend narrower words).
  function automatic logic even_parity(input logic [63:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/sprot_rx_fifo.sv
// First-word fall-through synchronous FIFO with an explicit occupancy counter,
// so full and empty stay distinguishable when the pointers are equal.
module sprot_rx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  // A pop while empty is ignored; a push while full only lands if a pop frees a slot.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  // Head word falls through; forced to zero when nothing is stored.
  assign rdata   = empty ? '0 : mem[rd_ptr];

  // Storage write.
  // NOTE: the data array has no reset; empty/count gate every read, so stale
  // contents are never visible and the array can map onto plain RAM.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // Pointers and occupancy; pointers wrap naturally because DEPTH is a power of two.
  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/sprot_rx.sv
// sprot receive endpoint: walks start/data/parity/stop on the serial line,
// pushes good words into a small FWFT FIFO and flags parity, framing and
// overflow events with registered one-cycle pulses.
module sprot_rx
  import sprot_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = $clog2(FIFO_DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sdata_i,
  output logic [DATA_W-1:0] rx_data_o,
  output logic              rx_valid_o,
  input  logic              rx_ready_i,
  output logic              parity_err_o,
  output logic              frame_err_o,
  output logic              overflow_o,
  output logic [CNT_W-1:0]  fifo_count_o
);

  localparam int BC_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  sprot_state_e      state;
  sprot_state_e      state_nx;
  logic [DATA_W-1:0] shift;
  logic [BC_W-1:0]   bit_cnt;
  logic              parity_ok;
  logic              last_bit;

  logic              shift_en;
  logic              cnt_clr;
  logic              par_latch;
  logic              good_word;
  logic              par_fail;
  logic              stop_fail;

  logic              fifo_pop;
  logic              fifo_full;
  logic              fifo_empty;

  assign last_bit = (bit_cnt == BC_W'(DATA_W - 1));

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Next-state decode; a start bit straight after STOP is taken from IDLE.
  // NOTE: state_nx gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (sdata_i == START_BIT) state_nx = DATA;
      DATA:    if (last_bit)             state_nx = PARITY;
      PARITY:                            state_nx = STOP;
      STOP:    state_nx = (sdata_i == STOP_BIT) ? IDLE : BREAK;
      BREAK:   if (sdata_i == IDLE_LVL)  state_nx = IDLE;
      default:                           state_nx = IDLE;
    endcase
  end

  // Per-state datapath controls and stop-bit verdicts.
  always_comb begin
    shift_en  = (state == DATA);
    cnt_clr   = (state == IDLE);
    par_latch = (state == PARITY);
    good_word = (state == STOP) && (sdata_i == STOP_BIT) &&  parity_ok;
    par_fail  = (state == STOP) && (sdata_i == STOP_BIT) && !parity_ok;
    stop_fail = (state == STOP) && (sdata_i != STOP_BIT);
  end

  // Deserializer: LSB arrives first, so shift in at the MSB end.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shift     <= '0;
      bit_cnt   <= '0;
      parity_ok <= 1'b0;
    end else begin
      if (shift_en) begin
        shift   <= {sdata_i, shift[DATA_W-1:1]};
        bit_cnt <= last_bit ? '0 : bit_cnt + 1'b1;
      end else if (cnt_clr) begin
        bit_cnt <= '0;
      end
      if (par_latch) parity_ok <= (even_parity(64'(shift)) == sdata_i);
    end
  end

  // Error pulses, registered so each lasts exactly the cycle after the stop bit.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      parity_err_o <= 1'b0;
      frame_err_o  <= 1'b0;
      overflow_o   <= 1'b0;
    end else begin
      parity_err_o <= par_fail;
      frame_err_o  <= stop_fail;
      overflow_o   <= good_word && fifo_full && !fifo_pop;
    end
  end

  assign rx_valid_o = !fifo_empty;
  assign fifo_pop   = rx_valid_o && rx_ready_i;

  sprot_rx_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (FIFO_DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (good_word),
    .wdata (shift),
    .pop   (fifo_pop),
    .rdata (rx_data_o),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count_o)
  );

endmodule

// File: tb/tb_sprot_rx.sv
// Self-checking bench for sprot_rx: directed scenarios followed by random
// frames, compared every cycle against a frame-level queue model.
module tb_sprot_rx;
  import sprot_pkg::*;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 4;
  localparam int CNT_W  = $clog2(DEPTH + 1);

  typedef enum int {EV_NONE, EV_GOOD, EV_PAR, EV_FRM} ev_e;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              sdata_i;
  logic              rx_ready_i;
  logic [DATA_W-1:0] rx_data_o;
  logic              rx_valid_o;
  logic              parity_err_o;
  logic              frame_err_o;
  logic              overflow_o;
  logic [CNT_W-1:0]  fifo_count_o;

  int checks = 0;
  int errors = 0;

  // Model: words the receiver should be holding, oldest first, plus the
  // pulses expected in the current cycle.
  logic [DATA_W-1:0] q[$];
  logic exp_par = 1'b0;
  logic exp_frm = 1'b0;
  logic exp_ovf = 1'b0;

  always #5 clk = ~clk;

  sprot_rx #(.DATA_W(DATA_W), .FIFO_DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .sdata_i      (sdata_i),
    .rx_data_o    (rx_data_o),
    .rx_valid_o   (rx_valid_o),
    .rx_ready_i   (rx_ready_i),
    .parity_err_o (parity_err_o),
    .frame_err_o  (frame_err_o),
    .overflow_o   (overflow_o),
    .fifo_count_o (fifo_count_o)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One line cycle, entered and left at the falling edge. Outputs are checked
  // against the model, inputs are driven, then the model advances over the
  // rising edge. ev tells the model what this bit completes.
  task automatic cycle(input logic b, input logic rdy, input ev_e ev, input logic [DATA_W-1:0] w);
    check("count", 32'(fifo_count_o), 32'(q.size()));
    check("valid", 32'(rx_valid_o), 32'(q.size() > 0));
    if (q.size() > 0) check("data", 32'(rx_data_o), 32'(q[0]));
    check("parity_err", 32'(parity_err_o), 32'(exp_par));
    check("frame_err", 32'(frame_err_o), 32'(exp_frm));
    check("overflow", 32'(overflow_o), 32'(exp_ovf));
    sdata_i    = b;
    rx_ready_i = rdy;
    @(posedge clk);
    if (!rst_n) begin
      q.delete();
      exp_par = 1'b0;
      exp_frm = 1'b0;
      exp_ovf = 1'b0;
    end else begin
      if (rdy && q.size() > 0) void'(q.pop_front());
      exp_par = (ev == EV_PAR);
      exp_frm = (ev == EV_FRM);
      exp_ovf = 1'b0;
      if (ev == EV_GOOD) begin
        if (q.size() < DEPTH) q.push_back(w);
        else                  exp_ovf = 1'b1;
      end
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) cycle(IDLE_LVL, rdy, EV_NONE, '0);
  endtask

  // Send one whole frame; rdy_stop is the consumer ready during the stop bit.
  task automatic send_frame(input logic [DATA_W-1:0] w, input logic bad_par,
                            input logic bad_stop, input logic rdy, input logic rdy_stop);
    logic [31:0] frame;
    logic        p;
    logic        stop_v;
    ev_e         ev;
    int          n;
    p      = logic'($countones(w) % 2) ^ bad_par;
    stop_v = bad_stop ? ~STOP_BIT : STOP_BIT;
    ev     = bad_stop ? EV_FRM : (bad_par ? EV_PAR : EV_GOOD);
    frame  = '0;
    frame[DATA_W+2:0] = {stop_v, p, w, START_BIT};
    n = frame_len(DATA_W);
    for (int i = 0; i < n; i++) begin
      if (i == n - 1) cycle(frame[i], rdy_stop, ev, w);
      else            cycle(frame[i], rdy, EV_NONE, '0);
    end
  endtask

  initial begin
    logic [DATA_W-1:0] w;
    logic [DATA_W-1:0] ff;
    logic              bp;
    logic              bs;
    logic              rdy;
    int                r;

    rst_n      = 1'b0;
    sdata_i    = IDLE_LVL;
    rx_ready_i = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_count", 32'(fifo_count_o), 32'd0);
    check("reset_valid", 32'(rx_valid_o), 32'd0);
    check("reset_data", 32'(rx_data_o), 32'd0);
    check("reset_perr", 32'(parity_err_o), 32'd0);
    check("reset_ferr", 32'(frame_err_o), 32'd0);
    check("reset_ovf", 32'(overflow_o), 32'd0);
    rst_n = 1'b1;
    idle(2, 1'b1);

    // Good 0xA5 with the consumer always ready: valid for exactly one cycle.
    send_frame(8'hA5, 1'b0, 1'b0, 1'b1, 1'b1);
    idle(3, 1'b1);

    // 0x01 with a wrong parity bit: parity pulse, nothing stored.
    send_frame(8'h01, 1'b1, 1'b0, 1'b1, 1'b1);
    idle(3, 1'b1);

    // 0x3C with a low stop bit, line held low 20 cycles, then good 0x5A.
    send_frame(8'h3C, 1'b0, 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 20; i++) cycle(1'b0, 1'b1, EV_NONE, '0);
    idle(1, 1'b1);
    send_frame(8'h5A, 1'b0, 1'b0, 1'b1, 1'b1);
    idle(3, 1'b1);

    // Overflow: five back-to-back frames with no consumer, then drain.
    for (int i = 1; i <= 5; i++) send_frame(DATA_W'(8'h11 * i), 1'b0, 1'b0, 1'b0, 1'b0);
    idle(2, 1'b0);
    idle(6, 1'b1);

    // Full FIFO with a pop coinciding with the fifth push: no overflow.
    for (int i = 0; i < 4; i++) send_frame(DATA_W'(8'hC0 + i), 1'b0, 1'b0, 1'b0, 1'b0);
    send_frame(8'hC4, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(2, 1'b0);
    idle(6, 1'b1);

    // Reset during data bit 4 of 0xFF with two words already buffered.
    send_frame(8'h81, 1'b0, 1'b0, 1'b0, 1'b0);
    send_frame(8'h82, 1'b0, 1'b0, 1'b0, 1'b0);
    ff = 8'hFF;
    cycle(START_BIT, 1'b0, EV_NONE, '0);
    for (int i = 0; i < 4; i++) cycle(ff[i], 1'b0, EV_NONE, '0);
    rst_n = 1'b0;
    cycle(ff[4], 1'b0, EV_NONE, '0);
    check("midrst_count", 32'(fifo_count_o), 32'd0);
    check("midrst_valid", 32'(rx_valid_o), 32'd0);
    check("midrst_data", 32'(rx_data_o), 32'd0);
    cycle(ff[5], 1'b0, EV_NONE, '0);
    cycle(ff[6], 1'b0, EV_NONE, '0);
    rst_n = 1'b1;
    cycle(ff[7], 1'b0, EV_NONE, '0);
    idle(3, 1'b0);
    send_frame(8'h0F, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(2, 1'b0);
    idle(4, 1'b1);

    // Random traffic: occasional parity/stop faults, random consumer and gaps.
    for (int n = 0; n < 150; n++) begin
      w   = DATA_W'($urandom);
      r   = int'($urandom_range(0, 9));
      bp  = (r == 0);
      bs  = (r == 1);
      rdy = ($urandom_range(0, 3) != 0);
      send_frame(w, bp, bs, rdy, logic'($urandom_range(0, 1)));
      if (bs) begin
        for (int i = 0; i < int'($urandom_range(0, 4)); i++) cycle(1'b0, rdy, EV_NONE, '0);
        idle(1, rdy);
      end else begin
        idle(int'($urandom_range(0, 2)), logic'($urandom_range(0, 1)));
      end
    end
    idle(8, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
